// File: rtl/seq_detect_frame_ctrl.sv
// ============================================================================
// seq_detect_frame_ctrl
// ----------------------------------------------------------------------------
// Frame sequencer for the 1011 sequence detector. Parallel words arrive over a
// valid/ready handshake and are serialised one bit per clock onto the
// detector's input, with no gaps between consecutive words of a frame. The
// detector is reset at the start of every frame. Its hits are counted with a
// saturating counter, and the total is reported with a one-cycle done pulse
// when the frame ends.
//
// Parameters:
//   DATA_W  bits per input word (serialised MSB-first by default)
//   CNT_W   width of the per-frame match counter (saturates at all-ones)
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous, active-low reset
//   in_valid     producer word valid
//   in_data      word to serialise
//   in_last      word is the last of its frame (sampled with in_data)
//   lsb_first    (only with SEQ_FRAME_LSB_FIRST_EN) serialise this word LSB-first
//   in_ready     controller accepts a word this cycle
//   det_bit      detector serial input
//   det_rst      detector reset (active-high, synchronous)
//   det_seen     detector seq_seen, reflects the bit driven one cycle earlier
//   match_count  hits in the last completed frame
//   done         one-cycle pulse at frame end
//   err          underrun flag, meaningful while done is high
//   busy         controller is not idle
//
// Optional feature macro: SEQ_FRAME_LSB_FIRST_EN
//   When defined, the lsb_first port is added. When it is undefined, every
//   word is serialised MSB-first.
// ============================================================================
module seq_detect_frame_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
`ifdef SEQ_FRAME_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              in_ready,
    output logic              det_bit,
    output logic              det_rst,
    input  logic              det_seen,
    output logic [CNT_W-1:0]  match_count,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int              BC_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] shift_q, shift_nx;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_nx;
    logic              last_q, last_nx;
    logic              lsb_q, lsb_nx;
    logic              pending_q, pending_nx;
    logic [CNT_W-1:0]  count_q, count_nx;
    logic              err_q, err_nx;

    logic              word_lsb;
    logic              hit;
    logic [CNT_W-1:0]  count_inc;

    // Bit order requested for the word currently offered by the producer.
`ifdef SEQ_FRAME_LSB_FIRST_EN
    assign word_lsb = lsb_first;
`else
    assign word_lsb = 1'b0;
`endif

    // det_seen lags the driven bit by one cycle, so a hit is attributed to
    // the previous cycle. It counts only when that cycle actually drove a
    // frame bit.
    assign hit       = pending_q && det_seen;
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

    // State register and datapath registers. An active-low reset aborts any
    // frame in progress without producing a done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            lsb_q     <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_q   <= shift_nx;
            bit_cnt_q <= bit_cnt_nx;
            last_q    <= last_nx;
            lsb_q     <= lsb_nx;
            pending_q <= pending_nx;
            count_q   <= count_nx;
            err_q     <= err_nx;
        end
    end

    // Next-state and output logic. In SHIFT, the final bit of a non-last word
    // is the only point where a word can be accepted. Accepting it there
    // reloads the shifter in the same cycle, so the serial stream has no
    // bubble. If the producer has nothing ready at that point, the frame ends
    // as an underrun: the detector is reset and the count is discarded.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift_q;
        bit_cnt_nx = bit_cnt_q;
        last_nx    = last_q;
        lsb_nx     = lsb_q;
        pending_nx = 1'b0;
        count_nx   = count_q;
        err_nx     = err_q;
        in_ready   = 1'b0;
        det_bit    = 1'b0;
        det_rst    = 1'b0;
        done       = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_nx   = in_data;
                    last_nx    = in_last;
                    lsb_nx     = word_lsb;
                    bit_cnt_nx = '0;
                    err_nx     = 1'b0;
                    state_nx   = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                det_rst  = 1'b1;
                count_nx = '0;
                state_nx = ST_SHIFT;
            end

            ST_SHIFT: begin
                det_bit    = lsb_q ? shift_q[0] : shift_q[DATA_W-1];
                pending_nx = 1'b1;
                if (hit) begin
                    count_nx = count_inc;
                end
                if (bit_cnt_q == LAST_BIT) begin
                    if (last_q) begin
                        state_nx = ST_DRAIN;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            shift_nx   = in_data;
                            last_nx    = in_last;
                            lsb_nx     = word_lsb;
                            bit_cnt_nx = '0;
                        end else begin
                            det_rst    = 1'b1;
                            err_nx     = 1'b1;
                            count_nx   = '0;
                            pending_nx = 1'b0;
                            state_nx   = ST_DONE;
                        end
                    end
                end else begin
                    shift_nx   = lsb_q ? {1'b0, shift_q[DATA_W-1:1]}
                                       : {shift_q[DATA_W-2:0], 1'b0};
                    bit_cnt_nx = bit_cnt_q + BC_W'(1);
                end
            end

            ST_DRAIN: begin
                if (hit) begin
                    count_nx = count_inc;
                end
                state_nx = ST_DONE;
            end

            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // The detector must stay in reset for as long as the controller is.
        if (!reset_n) begin
            det_rst = 1'b1;
        end
    end

    assign match_count = count_q;
    assign err         = err_q;
    assign busy        = (state != ST_IDLE);

endmodule
